hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-slot load-use hazard unit of the 5-stage MIPS pipeline.
- Tracks a per-register countdown of cycles until each in-flight result can be forwarded.
- Stalls the ID-stage instruction on RAW and WAW hazards of any depth.
- Freezes the whole front end while the data memory reports busy, and drives the pcWrite / IF_ID write-enable / ID-bubble controls.

Parameters:
- NREG, 32: number of architectural registers. Register 0 is hardwired zero and never busy.
- RW, 5: register-index width; must satisfy 2**RW >= NREG.
- ALU_LAT, 0: cycles before an ALU result is forwardable to a dependent instruction in ID.
- LOAD_LAT, 1: cycles before a load result is forwardable.
- CW, 3: countdown width; must satisfy 2**CW > max(ALU_LAT, LOAD_LAT).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- id_valid  in  1  a real (non-bubble) instruction is in ID.
- id_rs  in  RW  source register 1 of the ID instruction.
- id_rt  in  RW  source register 2 of the ID instruction.
- id_uses_rt  in  1  rt is read as a source (0 for I-type ALU ops and loads).
- id_rd  in  RW  destination register after RegDst selection.
- id_reg_write  in  1  the ID instruction writes id_rd.
- id_is_load  in  1  the ID instruction is a load (MemRead).
- id_flush  in  1  the ID instruction is squashed (branch/jump flush).
- mem_busy  in  1  data memory not ready; the pipeline must freeze.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- id_bubble  out  1  force control signals in ID/EX to zero (OPMux select).
- hz_state  out  2  FSM state: 0 RUN, 1 HAZ, 2 FREEZE.

Behaviour:
- Reset: all countdowns are 0, state is RUN, pc_write=1, if_id_write=1, id_bubble=0. Reset takes effect immediately and asynchronously, including mid-stall or mid-freeze.
- Scoreboard: cnt[r] is CW bits wide. cnt[0] is always 0, and writes to it are ignored.
- Hazard (combinational):
  - raw = id_valid & !id_flush & ((id_rs!=0 & cnt[id_rs]!=0) | (id_uses_rt & id_rt!=0 & cnt[id_rt]!=0)).
  - waw = id_valid & !id_flush & id_reg_write & id_rd!=0 & cnt[id_rd] > L, where L = id_is_load ? LOAD_LAT : ALU_LAT.
  - hz = raw | waw.
- Issue: occurs when id_valid & !id_flush & !hz & !mem_busy.
- Each clock edge while mem_busy is low:
  - Every nonzero cnt decrements by 1, saturating at 0.
  - On issue with id_reg_write and id_rd!=0, cnt[id_rd] loads L. The load overrides the decrement for that register in the same cycle.
- While mem_busy is high, all counts hold; no issue, no decrement.
- Outputs are combinational from the inputs and the counts, in priority order:
  - mem_busy: pc_write=0, if_id_write=0, id_bubble=0 (whole pipe holds).
  - else hz: pc_write=0, if_id_write=0, id_bubble=1.
  - else: pc_write=1, if_id_write=1, id_bubble=0.
- FSM (registered, next state):
  - FREEZE if mem_busy; else HAZ if hz; else RUN.
  - All transitions are legal. hz_state reports the registered state, so it lags the outputs by one cycle.
- Flush: id_flush suppresses both hazard detection and issue, so the flushed instruction never marks its rd. Counts already set are unaffected.
- Latency:
  - A dependent instruction stalls exactly cnt[src] cycles, plus any mem_busy cycles.
  - With ALU_LAT=0 there are no ALU stalls.
  - With LOAD_LAT=1 a back-to-back load-use gets one bubble.
- Same-register cases: rs==rt==rd on one instruction is legal. The ID instruction checks the pre-edge counts, then overwrites cnt[rd] on issue.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- When defined, the block adds these outputs:
  - stall_cycles (out, 32 bits): counts cycles with hz=1 and mem_busy=0.
  - freeze_cycles (out, 32 bits): counts mem_busy cycles.
- Both counters wrap modulo 2**32 and are cleared by rst.
- When not defined, neither port nor its logic exists, and all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 with random inputs -> pc_write=1, if_id_write=1, id_bubble=0, hz_state=0. Release reset; an issue of `add r3` followed by a read of r3 gives no stall (ALU_LAT=0).
- Load-use (defaults): `lw r5` issued, then `add r6,r5,r1` in ID -> exactly 1 cycle with id_bubble=1 and pc_write=0, then issue. hz_state reads 1 during the cycle after the bubble.
- Deep latency (LOAD_LAT=3): `lw r7`, then `sub r8,r7,r2` -> 3 bubble cycles. With rt-only use and id_uses_rt=0 -> 0 bubbles.
- WAW (LOAD_LAT=3, ALU_LAT=0): `lw r9`, then `addi r9` -> stalls until cnt[r9]=0 (3 cycles). An instruction with rd=r0 never stalls and never marks r0.
- Freeze: mem_busy=1 for 4 cycles while cnt[r5]=1 -> all enables 0, id_bubble=0, cnt[r5] still 1 afterwards. The dependent then takes 1 bubble. With HAZARD_STALL_CNT_EN defined: freeze_cycles=4, stall_cycles=1.
- Flush plus async reset: flushed `lw r4` leaves cnt[r4]=0, so a following `add r2,r4,r4` gets no bubble. Asserting rst mid-stall clears the stall in the same cycle, without a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Per-register countdown scoreboard that stalls ID on RAW/WAW
//            hazards and freezes the front end while data memory is busy.
//            Optional stall/freeze counters: define HAZARD_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int RW       = 5,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic          id_is_load,
  input  logic          id_flush,
  input  logic          mem_busy,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          id_bubble,
  output logic [1:0]    hz_state
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   freeze_cycles
`endif
);

  localparam logic [CW-1:0] ALU_L  = CW'(ALU_LAT);
  localparam logic [CW-1:0] LOAD_L = CW'(LOAD_LAT);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HAZ    = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_nxt;

  logic [CW-1:0] cnt [NREG];
  logic [CW-1:0] cnt_rs;
  logic [CW-1:0] cnt_rt;
  logic [CW-1:0] cnt_rd;
  logic [CW-1:0] lat;
  logic          live;
  logic          raw;
  logic          waw;
  logic          hz;
  logic          issue;
  logic          mark;

  // Indices at or above NREG (and r0) read as idle.
  always_comb begin
    cnt_rs = '0;
    cnt_rt = '0;
    cnt_rd = '0;
    if (id_rs != '0 && int'(id_rs) < NREG) cnt_rs = cnt[id_rs];
    if (id_rt != '0 && int'(id_rt) < NREG) cnt_rt = cnt[id_rt];
    if (id_rd != '0 && int'(id_rd) < NREG) cnt_rd = cnt[id_rd];
  end

  assign lat   = id_is_load ? LOAD_L : ALU_L;
  assign live  = id_valid & ~id_flush;
  assign raw   = live & ((cnt_rs != '0) | (id_uses_rt & (cnt_rt != '0)));
  assign waw   = live & id_reg_write & (id_rd != '0) & (cnt_rd > lat);
  assign hz    = raw | waw;
  assign issue = live & ~hz & ~mem_busy;
  assign mark  = issue & id_reg_write & (id_rd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (!mem_busy) begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0)
          cnt[r] <= '0;
        else if (mark && int'(id_rd) == r)
          cnt[r] <= lat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_nxt;
  end

  // Enables are forced open while reset is held, independent of the inputs.
  always_comb begin
    state_nxt   = ST_RUN;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_bubble   = 1'b0;
    if (mem_busy)  state_nxt = ST_FREEZE;
    else if (hz)   state_nxt = ST_HAZ;
    if (rst) begin
      if (mem_busy) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (hz) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_bubble   = 1'b1;
      end
    end
  end

  assign hz_state = state_q;

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles  <= '0;
      freeze_cycles <= '0;
    end else begin
      if (hz && !mem_busy) stall_cycles  <= stall_cycles + 32'd1;
      if (mem_busy)        freeze_cycles <= freeze_cycles + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Directed scoreboard bench for hazard_scoreboard; instance A uses
//            default latencies, instance B uses LOAD_LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       flush;
    logic       busy;
  } in_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  in_t  ia = '0;
  in_t  ib = '0;

  logic       a_pw, a_ifw, a_bub, b_pw, b_ifw, b_bub;
  logic [1:0] a_st, b_st;

  logic [4:0] qa[$];
  logic [4:0] qb[$];
  string      na[$];
  string      nb[$];
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] a_stall, a_freeze, b_stall, b_freeze;
  logic [63:0] qca[$];
  logic [63:0] qcb[$];
`endif

  hazard_scoreboard u_a (
    .clk(clk), .rst(rst),
    .id_valid(ia.valid), .id_rs(ia.rs), .id_rt(ia.rt), .id_uses_rt(ia.uses_rt),
    .id_rd(ia.rd), .id_reg_write(ia.rw), .id_is_load(ia.ld), .id_flush(ia.flush),
    .mem_busy(ia.busy),
    .pc_write(a_pw), .if_id_write(a_ifw), .id_bubble(a_bub), .hz_state(a_st)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cycles(a_stall), .freeze_cycles(a_freeze)
`endif
  );

  hazard_scoreboard #(.LOAD_LAT(3)) u_b (
    .clk(clk), .rst(rst),
    .id_valid(ib.valid), .id_rs(ib.rs), .id_rt(ib.rt), .id_uses_rt(ib.uses_rt),
    .id_rd(ib.rd), .id_reg_write(ib.rw), .id_is_load(ib.ld), .id_flush(ib.flush),
    .mem_busy(ib.busy),
    .pc_write(b_pw), .if_id_write(b_ifw), .id_bubble(b_bub), .hz_state(b_st)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cycles(b_stall), .freeze_cycles(b_freeze)
`endif
  );

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  always @(negedge clk) begin
    logic [4:0] e;
    string      n;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      n = na.pop_front();
      total++;
      if ({a_pw, a_ifw, a_bub, a_st} === e) passed++;
      else $display("FAIL A.%s got {pw,ifw,bub,st}=%b exp=%b", n, {a_pw, a_ifw, a_bub, a_st}, e);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      n = nb.pop_front();
      total++;
      if ({b_pw, b_ifw, b_bub, b_st} === e) passed++;
      else $display("FAIL B.%s got {pw,ifw,bub,st}=%b exp=%b", n, {b_pw, b_ifw, b_bub, b_st}, e);
    end
`ifdef HAZARD_STALL_CNT_EN
    if (qca.size() > 0) begin
      logic [63:0] c;
      c = qca.pop_front();
      total++;
      if ({a_stall, a_freeze} === c) passed++;
      else $display("FAIL A.counters got stall=%0d freeze=%0d exp stall=%0d freeze=%0d",
                    a_stall, a_freeze, c[63:32], c[31:0]);
    end
    if (qcb.size() > 0) begin
      logic [63:0] c;
      c = qcb.pop_front();
      total++;
      if ({b_stall, b_freeze} === c) passed++;
      else $display("FAIL B.counters got stall=%0d freeze=%0d exp stall=%0d freeze=%0d",
                    b_stall, b_freeze, c[63:32], c[31:0]);
    end
`endif
  end

  function automatic in_t I(input int v, input int rs, input int rt, input int u,
                            input int rd, input int w, input int ld, input int fl,
                            input int bz);
    in_t x;
    x.valid   = 1'(v);
    x.rs      = 5'(rs);
    x.rt      = 5'(rt);
    x.uses_rt = 1'(u);
    x.rd      = 5'(rd);
    x.rw      = 1'(w);
    x.ld      = 1'(ld);
    x.flush   = 1'(fl);
    x.busy    = 1'(bz);
    return x;
  endfunction

  // Expected {pc_write, if_id_write, id_bubble, hz_state}; both enables move together.
  function automatic logic [4:0] E(input int pw, input int bub, input int st);
    return {1'(pw), 1'(pw), 1'(bub), 2'(st)};
  endfunction

  task automatic drive(input bit which, input logic r, input in_t v,
                       input logic [4:0] exp, input string nm);
    @(posedge clk);
    #1;
    rst = r;
    if (!which) begin
      ia = v; ib = '0;
      qa.push_back(exp); na.push_back(nm);
    end else begin
      ib = v; ia = '0;
      qb.push_back(exp); nb.push_back(nm);
    end
  endtask

  initial begin
    logic [31:0] tmp;
    in_t dep5, sub8, addi9, lw9, idle;
    dep5  = I(1, 5, 1, 1, 6, 1, 0, 0, 0);
    sub8  = I(1, 7, 2, 1, 8, 1, 0, 0, 0);
    addi9 = I(1, 1, 0, 0, 9, 1, 0, 0, 0);
    lw9   = I(1, 1, 0, 0, 9, 1, 1, 0, 0);
    idle  = '0;

    // Reset held with random inputs: enables forced open, state RUN.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      tmp = $urandom; ia = tmp[$bits(in_t)-1:0];
      tmp = $urandom; ib = tmp[$bits(in_t)-1:0];
      qa.push_back(E(1, 0, 0)); na.push_back("reset");
      qb.push_back(E(1, 0, 0)); nb.push_back("reset");
    end

    // Instance A: ALU_LAT=0, LOAD_LAT=1
    drive(0, 1, I(1, 1, 2, 1, 3, 1, 0, 0, 0), E(1, 0, 0), "add_r3");
    drive(0, 1, I(1, 3, 3, 1, 4, 1, 0, 0, 0), E(1, 0, 0), "use_r3_nostall");
    drive(0, 1, I(1, 1, 0, 0, 5, 1, 1, 0, 0), E(1, 0, 0), "lw_r5");
    drive(0, 1, dep5,                         E(0, 1, 0), "loaduse_bubble");
    drive(0, 1, dep5,                         E(1, 0, 1), "loaduse_issue");
    drive(0, 1, I(1, 1, 0, 0, 5, 1, 1, 0, 0), E(1, 0, 0), "lw_r5_again");
    drive(0, 1, I(1, 5, 1, 1, 6, 1, 0, 0, 1), E(0, 0, 0), "freeze0");
    for (int k = 1; k < 4; k++)
      drive(0, 1, I(1, 5, 1, 1, 6, 1, 0, 0, 1), E(0, 0, 2), "freeze_hold");
    drive(0, 1, dep5,                         E(0, 1, 2), "post_freeze_bubble");
    drive(0, 1, dep5,                         E(1, 0, 1), "post_freeze_issue");
    drive(0, 1, idle,                         E(1, 0, 0), "idle");
`ifdef HAZARD_STALL_CNT_EN
    qca.push_back({32'd2, 32'd4});
`endif
    drive(0, 1, I(1, 1, 0, 0, 4, 1, 1, 1, 0), E(1, 0, 0), "flushed_lw_r4");
    drive(0, 1, I(1, 4, 4, 1, 2, 1, 0, 0, 0), E(1, 0, 0), "use_r4_nostall");
    drive(0, 1, I(1, 1, 0, 0, 5, 1, 1, 0, 0), E(1, 0, 0), "lw_r5_c");
    drive(0, 1, I(1, 5, 1, 1, 6, 1, 0, 1, 0), E(1, 0, 0), "flushed_dependent");
    drive(0, 1, I(1, 1, 0, 0, 0, 1, 1, 0, 0), E(1, 0, 0), "lw_r0");
    drive(0, 1, I(1, 0, 0, 1, 7, 1, 0, 0, 0), E(1, 0, 0), "use_r0");

    // Instance B: ALU_LAT=0, LOAD_LAT=3
    drive(1, 1, I(1, 1, 0, 0, 7, 1, 1, 0, 0), E(1, 0, 0), "lw_r7");
    drive(1, 1, sub8,                         E(0, 1, 0), "deep_bub1");
    drive(1, 1, sub8,                         E(0, 1, 1), "deep_bub2");
    drive(1, 1, sub8,                         E(0, 1, 1), "deep_bub3");
    drive(1, 1, sub8,                         E(1, 0, 1), "deep_issue");
    drive(1, 1, I(1, 1, 0, 0, 7, 1, 1, 0, 0), E(1, 0, 0), "lw_r7_again");
    drive(1, 1, I(1, 1, 7, 0, 10, 1, 0, 0, 0), E(1, 0, 0), "rt_unused_nostall");
    drive(1, 1, idle,                         E(1, 0, 0), "drain1");
    drive(1, 1, idle,                         E(1, 0, 0), "drain2");
    drive(1, 1, lw9,                          E(1, 0, 0), "lw_r9");
    drive(1, 1, addi9,                        E(0, 1, 0), "waw_bub1");
    drive(1, 1, addi9,                        E(0, 1, 1), "waw_bub2");
    drive(1, 1, addi9,                        E(0, 1, 1), "waw_bub3");
    drive(1, 1, addi9,                        E(1, 0, 1), "waw_issue");
    drive(1, 1, lw9,                          E(1, 0, 0), "lw_r9_b");
    drive(1, 1, lw9,                          E(1, 0, 0), "waw_load_equal_lat");
    drive(1, 1, addi9,                        E(0, 1, 0), "waw_reload_bub1");
    drive(1, 1, addi9,                        E(0, 1, 1), "waw_reload_bub2");
    drive(1, 1, addi9,                        E(0, 1, 1), "waw_reload_bub3");
    drive(1, 1, addi9,                        E(1, 0, 1), "waw_reload_issue");
    drive(1, 1, I(1, 1, 0, 0, 5, 1, 1, 0, 0), E(1, 0, 0), "lw_r5");
    drive(1, 1, dep5,                         E(0, 1, 0), "stall_before_rst1");
    drive(1, 1, dep5,                         E(0, 1, 1), "stall_before_rst2");
    drive(1, 0, dep5,                         E(1, 0, 0), "async_rst_mid_stall");
    drive(1, 1, dep5,                         E(1, 0, 0), "after_rst_nostall");
    drive(1, 1, idle,                         E(1, 0, 0), "final_idle");
`ifdef HAZARD_STALL_CNT_EN
    qcb.push_back({32'd0, 32'd0});
`endif

    for (int k = 0; k < 20; k++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk);
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      total++;
      $display("FAIL drain pending A=%0d B=%0d required 0", qa.size(), qb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
